// File: rtl/riscv_mc_pkg.sv
// rtl/riscv_mc_pkg.sv - shared constants for the multicycle RISC-V controller
//
// Opcode constants, FSM state encodings, ALU control codes, ALU-op classes
// and immediate-type codes used by mc_control_unit and mc_alu_decoder.
package riscv_mc_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Operation class handed from the FSM to the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format implied by the opcode; unknown opcodes fall back to I
    function automatic logic [1:0] imm_type(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_B:    return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// rtl/mc_alu_decoder.sv - maps ALU-op class and funct fields to alucontrol
//
// Ports:
//   aluop_i      operation class from the FSM (add / sub / funct-decoded)
//   funct3_i     instr[14:12]
//   funct7b5_i   instr[30]
//   op5_i        instr[5], distinguishes R-type from I-type
//   alucontrol_o ALU operation code
module mc_alu_decoder
    import riscv_mc_pkg::*;
(
    input  aluop_t      aluop_i,
    input  logic [2:0]  funct3_i,
    input  logic        funct7b5_i,
    input  logic        op5_i,
    output logic [2:0]  alucontrol_o
);

    always_comb begin
        alucontrol_o = ALU_ADD;
        case (aluop_i)
            ALUOP_SUB: alucontrol_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // instr[30] is only a sub selector for R-type; for addi it
                    // is an immediate bit, hence the op5 qualifier
                    3'b000:  alucontrol_o = (funct7b5_i && op5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol_o = ALU_SLT;
                    3'b110:  alucontrol_o = ALU_OR;
                    3'b111:  alucontrol_o = ALU_AND;
                    default: alucontrol_o = ALU_ADD;
                endcase
            end
            default: alucontrol_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - multicycle RISC-V controller FSM
//
// Sequences fetch/decode/execute/writeback over a shared datapath with one
// memory port, stalling on mem_ready. Outputs are decoded from the state;
// irwrite/pcwrite in fetch are qualified by mem_ready, pcwrite in branch by
// zero, and immsrc follows op in every state.
// Ports: clk, rst_n (async active-low); op, funct3, funct7b5, zero, mem_ready
// in; mem_req, memwrite, irwrite, pcwrite, regwrite, adrsrc, alusrca,
// alusrcb, resultsrc, immsrc, alucontrol out.
// Optional: MC_ILLEGAL_TRAP_EN adds illegal_instr and a sticky S_TRAP state.
module mc_control_unit
    import riscv_mc_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        memwrite,
    output logic        irwrite,
    output logic        pcwrite,
    output logic        regwrite,
    output logic        adrsrc,
    output logic [1:0]  alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  resultsrc,
    output logic [1:0]  immsrc,
`ifdef MC_ILLEGAL_TRAP_EN
    output logic        illegal_instr,
`endif
    output logic [2:0]  alucontrol
);

    state_t state_q, state_d;
    aluop_t aluop;
    logic   mem_req_s, memwrite_s, irwrite_s, pcwrite_s, regwrite_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= state_t'(RESET_STATE);
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_B:         state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXECR,
            S_EXECI,
            S_JAL:    state_d = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:   state_d = S_TRAP;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req_s  = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        pcwrite_s  = 1'b0;
        regwrite_s = 1'b0;
        adrsrc     = 1'b0;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        resultsrc  = 2'b00;
        aluop      = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req_s = 1'b1;
                irwrite_s = mem_ready;
                pcwrite_s = mem_ready;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            S_MEMRD: begin
                mem_req_s = 1'b1;
                adrsrc    = 1'b1;
            end
            S_MEMWB: begin
                resultsrc  = 2'b01;
                regwrite_s = 1'b1;
            end
            S_MEMWR: begin
                mem_req_s  = 1'b1;
                memwrite_s = 1'b1;
                adrsrc     = 1'b1;
            end
            S_EXECR: begin
                alusrca = 2'b10;
                aluop   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB:  regwrite_s = 1'b1;
            S_BRANCH: begin
                alusrca = 2'b10;
                aluop   = ALUOP_SUB;
                case (funct3)
                    3'b000:  pcwrite_s = zero;
                    3'b001:  pcwrite_s = ~zero;
                    default: pcwrite_s = 1'b0;
                endcase
            end
            S_JAL: begin
                alusrca   = 2'b01;
                alusrcb   = 2'b10;
                pcwrite_s = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset drops the state to fetch asynchronously, but fetch itself would
    // request memory; force every strobe low for the duration of reset.
    assign mem_req  = mem_req_s  & rst_n;
    assign memwrite = memwrite_s & rst_n;
    assign irwrite  = irwrite_s  & rst_n;
    assign pcwrite  = pcwrite_s  & rst_n;
    assign regwrite = regwrite_s & rst_n;
    assign immsrc   = imm_type(op);

`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal_instr = (state_q == S_TRAP) & rst_n;
`endif

    mc_alu_decoder u_alu_decoder (
        .aluop_i      (aluop),
        .funct3_i     (funct3),
        .funct7b5_i   (funct7b5),
        .op5_i        (op[5]),
        .alucontrol_o (alucontrol)
    );

endmodule
